// File: rtl/fadd_stream_acc.sv
// rtl/fadd_stream_acc.sv - streaming IEEE-754 single-precision packet accumulator around a combinational fadd.
// Optional sticky NaN/Inf outputs are built when FADD_ACC_FLAGS_EN is defined.
module fadd (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic        a_nan, b_nan, a_inf, b_inf, a_big;
  logic        sx, sy;
  logic [7:0]  ex, ey, ex_e, ey_e, d, lim, shamt;
  logic [23:0] sigx, sigy, sig;
  logic [26:0] x_al, y27, y_al, n;
  logic [27:0] s;
  logic [9:0]  e, e_r;
  logic [24:0] sig_r;
  logic [22:0] mant;
  logic        up, hidden;

  always_comb begin
    a_nan = (a_i[30:23] == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan = (b_i[30:23] == 8'hFF) && (b_i[22:0] != 23'd0);
    a_inf = (a_i[30:23] == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf = (b_i[30:23] == 8'hFF) && (b_i[22:0] == 23'd0);
    // Order operands by magnitude so the aligned difference is never negative.
    a_big = a_i[30:0] >= b_i[30:0];
    sx    = a_big ? a_i[31] : b_i[31];
    sy    = a_big ? b_i[31] : a_i[31];
    ex    = a_big ? a_i[30:23] : b_i[30:23];
    ey    = a_big ? b_i[30:23] : a_i[30:23];
    sigx  = {ex != 8'd0, a_big ? a_i[22:0] : b_i[22:0]};
    sigy  = {ey != 8'd0, a_big ? b_i[22:0] : a_i[22:0]};
    ex_e  = (ex == 8'd0) ? 8'd1 : ex;
    ey_e  = (ey == 8'd0) ? 8'd1 : ey;
    d     = ex_e - ey_e;
    x_al  = {sigx, 3'b000};
    y27   = {sigy, 3'b000};
    if (d >= 8'd27)
      y_al = {26'd0, |sigy};
    else
      y_al = (y27 >> d) | {26'd0, |(y27 & ((27'd1 << d) - 27'd1))};
    s = (sx == sy) ? ({1'b0, x_al} + {1'b0, y_al}) : ({1'b0, x_al} - {1'b0, y_al});

    lim   = ex_e - 8'd1;
    shamt = 8'd0;
    if (s[27]) begin
      n = {s[27:2], s[1] | s[0]};
      e = {2'b00, ex_e} + 10'd1;
    end else begin
      shamt = ({3'b000, lzc27(s[26:0])} > lim) ? lim : {3'b000, lzc27(s[26:0])};
      n     = s[26:0] << shamt;
      e     = {2'b00, ex_e - shamt};
    end

    // Round to nearest, ties to even, on guard/round/sticky.
    sig    = n[26:3];
    up     = n[2] & (n[1] | n[0] | sig[0]);
    sig_r  = {1'b0, sig} + {24'd0, up};
    e_r    = e + {9'd0, sig_r[24]};
    mant   = sig_r[24] ? sig_r[23:1] : sig_r[22:0];
    hidden = sig_r[24] | sig_r[23];

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31])))
      sum_o = 32'h7FC00000;
    else if (a_inf)
      sum_o = a_i;
    else if (b_inf)
      sum_o = b_i;
    else if (s == 28'd0)
      sum_o = {sx & sy, 31'd0};
    else if (hidden && (e_r >= 10'd255))
      sum_o = {sx, 8'hFF, 23'd0};
    else
      sum_o = {sx, hidden ? e_r[7:0] : 8'd0, mant};
  end
endmodule

module fadd_stream_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count
`ifdef FADD_ACC_FLAGS_EN
  ,
  output logic             out_nan,
  output logic             out_inf
`endif
);
  typedef enum logic {ACC, HOLD} state_t;

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d, sum_q, sum_d, fadd_res;
  logic [CNT_W-1:0]   cnt_q, cnt_d, count_q, count_d, cnt_inc;
  logic               accept;

  fadd u_fadd (.a_i(acc_q), .b_i(in_data), .sum_o(fadd_res));

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign out_sum   = sum_q;
  assign out_count = count_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          acc_d = fadd_res;
          cnt_d = cnt_inc;
          if (in_last) begin
            sum_d   = fadd_res;
            count_d = cnt_inc;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ACC;
          acc_d   = 32'd0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= 32'd0;
      cnt_q   <= '0;
      sum_q   <= 32'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      count_q <= count_d;
    end
  end

`ifdef FADD_ACC_FLAGS_EN
  logic nan_q, nan_d, inf_q, inf_d;

  always_comb begin
    nan_d = nan_q;
    inf_d = inf_q;
    if (accept) begin
      nan_d = nan_q | ((fadd_res[30:23] == 8'hFF) && (fadd_res[22:0] != 23'd0));
      inf_d = inf_q | ((fadd_res[30:23] == 8'hFF) && (fadd_res[22:0] == 23'd0));
    end else if (out_valid && out_ready) begin
      nan_d = 1'b0;
      inf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else begin
      nan_q <= nan_d;
      inf_q <= inf_d;
    end
  end

  assign out_nan = nan_q;
  assign out_inf = inf_q;
`endif
endmodule
